// File: rtl/aes_spi_pkg.sv
// ---------------------------------------------------------------------------
// aes_spi_pkg
// Shared definitions for the AES SPI host: the controller state enum and the
// block/frame widths used by the shift registers.
// ---------------------------------------------------------------------------
package aes_spi_pkg;

    // Width of one AES block (key, plaintext or cyphertext).
    localparam int BLOCK_W = 128;

    // Width of the outbound frame: plaintext followed by key.
    localparam int FRAME_W = 256;

    // Controller states, in transfer order.
    typedef enum logic [2:0] {
        IDLE,
        SHIFT_OUT,
        WAIT_DONE,
        SETTLE,
        SHIFT_IN
    } spi_host_state_t;

endpackage

// File: rtl/sck_gen.sv
// ---------------------------------------------------------------------------
// sck_gen
// SPI clock generator. While run is high, sck toggles every CLK_DIV clk
// cycles, starting low. rise/fall are combinational strobes that announce the
// edge sck will make at the coming clk edge. A consumer acting on a strobe
// therefore updates its own flops in the same cycle that sck changes.
//
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; forces sck low and clears the divider
//   run   - enables toggling; low holds sck low and the divider at zero
//   sck   - SPI clock, idle low, driven from a flop
//   rise  - high in the cycle before sck goes 0->1
//   fall  - high in the cycle before sck goes 1->0
//
// Parameters:
//   CLK_DIV - sck half-period in clk cycles (>= 2)
// ---------------------------------------------------------------------------
module sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          edge_now;

    // The edge happens when the divider has spent CLK_DIV cycles in the
    // current half-period.
    assign edge_now = run && (cnt == CW'(CLK_DIV - 1));
    assign rise     = edge_now && !sck;
    assign fall     = edge_now && sck;

    // Divider and sck flop. Dropping run restarts the half-period count, so
    // the first rise always comes CLK_DIV cycles after run goes high.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (edge_now) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes_spi_host.sv
// ---------------------------------------------------------------------------
// aes_spi_host
// SPI mode-0 master for the AES core's SPI port. A start pulse captures key
// and plaintext, raises load and shifts the 256-bit frame {plaintext,key}
// MSB first. It then drops load, waits for the (synchronized) done flag,
// idles sck low for CLK_DIV cycles and clocks 128 cyphertext bits in from
// sdo. The result is presented with a one-cycle valid strobe.
//
// Optional feature: define AES_SPI_HOST_TIMEOUT_EN to bound the done wait by
// TIMEOUT_CYCLES. On expiry, error is set and the block returns to IDLE
// without a valid. Without the macro, error is tied low and the wait is
// unbounded.
//
// Ports:
//   clk        - system clock (single domain)
//   reset      - synchronous, active-high
//   start      - request pulse, sampled only while busy is low
//   key        - 128-bit key, captured on accepted start
//   plaintext  - 128-bit plaintext, captured on accepted start
//   sck        - SPI clock, idle low
//   sdi        - serial data to peripheral
//   load       - frame-load strobe, high for the whole outbound frame
//   done       - asynchronous completion flag from the peripheral
//   sdo        - serial data from peripheral
//   cyphertext - last received result, held until the next completion
//   busy       - high from the cycle after accept until the valid cycle
//   valid      - one-cycle pulse when cyphertext updates
//   error      - sticky done-timeout flag, cleared by the next accept
//
// Parameters:
//   CLK_DIV        - sck half-period in clk cycles (>= 2)
//   TIMEOUT_CYCLES - done-wait limit (timeout build only)
// ---------------------------------------------------------------------------
module aes_spi_host
    import aes_spi_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] plaintext,
    output logic               sck,
    output logic               sdi,
    output logic               load,
    input  logic               done,
    input  logic               sdo,
    output logic [BLOCK_W-1:0] cyphertext,
    output logic               busy,
    output logic               valid,
    output logic               error
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    spi_host_state_t state, state_next;

    logic               run, rise, fall;
    logic               accept, out_last, in_last, settle_end, timeout;
    logic               done_meta, done_sync;
    logic               load_q, valid_q;
    logic [FRAME_W-1:0] out_sr;
    logic [BLOCK_W-1:0] in_sr;
    logic [8:0]         bit_cnt;
    logic [CW-1:0]      settle_cnt;

    sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .sck   (sck),
        .rise  (rise),
        .fall  (fall)
    );

    // sdi is the top bit of the outbound shift register, so it comes straight
    // from a flop and reads 0 once the frame has been shifted out.
    assign sdi   = out_sr[FRAME_W-1];
    assign load  = load_q;
    assign valid = valid_q;

    // busy also covers the valid cycle, in which the state is already IDLE.
    assign busy  = (state != IDLE) || valid_q;

    // Two-flop synchronizer for the asynchronous done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_meta <= 1'b0;
            done_sync <= 1'b0;
        end else begin
            done_meta <= done;
            done_sync <= done_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Terminal bits are detected on the falling-edge strobe
    // so the state changes in the same cycle as the last sck fall.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept)     state_next = SHIFT_OUT;
            SHIFT_OUT: if (out_last)   state_next = WAIT_DONE;
            WAIT_DONE: if (done_sync)  state_next = SETTLE;
                       else if (timeout) state_next = IDLE;
            SETTLE:    if (settle_end) state_next = SHIFT_IN;
            SHIFT_IN:  if (in_last)    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Control decode: clock enable for sck_gen and the one-cycle events that
    // the datapath and the FSM act on.
    always_comb begin
        run        = (state == SHIFT_OUT) || (state == SHIFT_IN);
        accept     = (state == IDLE) && !valid_q && start;
        out_last   = (state == SHIFT_OUT) && fall && (bit_cnt == 9'd255);
        in_last    = (state == SHIFT_IN) && fall && (bit_cnt == 9'd127);
        settle_end = (state == SETTLE) && (settle_cnt == CW'(CLK_DIV - 1));
    end

    // Datapath: frame capture and shift-out on falls, shift-in on rises,
    // bit/settle counters, load and the result register with its strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_sr     <= '0;
            in_sr      <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            load_q     <= 1'b0;
            valid_q    <= 1'b0;
            cyphertext <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_sr  <= {plaintext, key};
                        load_q  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                SHIFT_OUT: begin
                    if (fall) begin
                        out_sr <= {out_sr[FRAME_W-2:0], 1'b0};
                        if (out_last) begin
                            load_q  <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 9'd1;
                        end
                    end
                end
                WAIT_DONE: begin
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                SHIFT_IN: begin
                    if (rise) begin
                        in_sr <= {in_sr[BLOCK_W-2:0], sdo};
                    end
                    if (fall) begin
                        if (in_last) begin
                            cyphertext <= in_sr;
                            valid_q    <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AES_SPI_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          error_q;

    // to_cnt holds the number of cycles already spent in WAIT_DONE, so the
    // timeout fires on the last of TIMEOUT_CYCLES cycles without done.
    assign timeout = (state == WAIT_DONE) && !done_sync &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign error   = error_q;

    // Done-wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == WAIT_DONE) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
            if (accept) begin
                error_q <= 1'b0;
            end else if (timeout) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    // The bit counter is cleared on each terminal bit, so it can never run
    // past 255.
    assert property (@(posedge clk) disable iff (reset) bit_cnt <= 9'd255);

    // Parameter sanity: the divider needs at least two cycles per half-period.
    assert property (@(posedge clk) (CLK_DIV >= 2) && (TIMEOUT_CYCLES >= 1));

endmodule

// File: tb/tb_aes_spi_host.sv
// ---------------------------------------------------------------------------
// tb_aes_spi_host
// Self-checking bench for aes_spi_host with CLK_DIV=2 and TIMEOUT_CYCLES=1000.
// A behavioral peripheral captures the outbound frame on sck rises while load
// is high, raises done after a programmable delay (or holds it high), and
// returns a fixed cyphertext on sdo, advancing on sck falls.
// ---------------------------------------------------------------------------
module tb_aes_spi_host;

    localparam int CD = 2;
    localparam int TO = 1000;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         sck;
    logic         sdi;
    logic         load;
    logic         done;
    logic         sdo;
    logic [127:0] cyphertext;
    logic         busy;
    logic         valid;
    logic         error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Peripheral configuration, written only by the stimulus process.
    // done_delay: -2 = done held high, -1 = never, N >= 0 = cycles after load falls.
    logic [127:0] tx_result = '0;
    int           done_delay = 50;

    // Peripheral observation state, written only by the peripheral process.
    logic [255:0] rx_frame;
    logic [127:0] tx_sr;
    int  rx_cnt, rise_cnt, sdi_glitch, done_timer, done_hold;
    int  load_rise_cyc, load_fall_cyc, first_in_rise_cyc;
    bit  tx_active, sck_prev, load_prev, sdi_prev;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           delay;
        bit           spam;
    } vec_t;

    vec_t vecs[4];

    aes_spi_host #(
        .CLK_DIV        (CD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .plaintext  (plaintext),
        .sck        (sck),
        .sdi        (sdi),
        .load       (load),
        .done       (done),
        .sdo        (sdo),
        .cyphertext (cyphertext),
        .busy       (busy),
        .valid      (valid),
        .error      (error)
    );

    // Free-running clock and a cycle counter that counts rising edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioral peripheral, evaluated on the falling clk edge so every DUT
    // output has settled. sck edges are found by comparing with the value
    // seen half a clk earlier.
    always @(negedge clk) begin
        if (reset) begin
            rx_cnt = 0; rise_cnt = 0; sdi_glitch = 0;
            done_timer = -1; done_hold = 0; tx_active = 0;
            sck_prev = 0; load_prev = 0; sdi_prev = 0;
            done = 1'b0; sdo = 1'b0; tx_sr = '0; rx_frame = '0;
            first_in_rise_cyc = -1;
        end else begin
            if (done_delay == -2) done = 1'b1;
            if (load && !load_prev) begin
                rx_cnt = 0; rise_cnt = 0; sdi_glitch = 0;
                tx_active = 0; done_timer = -1; first_in_rise_cyc = -1;
                load_rise_cyc = cyc;
                if (done_delay != -2) done = 1'b0;
            end
            if (sck && !sck_prev) begin
                rise_cnt++;
                if (sdi != sdi_prev) sdi_glitch++;
                if (load) begin
                    rx_frame = {rx_frame[254:0], sdi};
                    rx_cnt++;
                end else if (tx_active && first_in_rise_cyc < 0) begin
                    first_in_rise_cyc = cyc;
                end
            end
            if (!sck && sck_prev && tx_active) begin
                tx_sr = {tx_sr[126:0], 1'b0};
                sdo   = tx_sr[127];
            end
            if (!load && load_prev) begin
                load_fall_cyc = cyc;
                if (done_delay == -2) begin
                    tx_sr = tx_result; sdo = tx_sr[127]; tx_active = 1;
                end else if (done_delay >= 0) begin
                    done_timer = done_delay;
                end
            end
            if (done_timer > 0) begin
                done_timer--;
            end else if (done_timer == 0) begin
                done = 1'b1; done_hold = 10; done_timer = -1;
                tx_sr = tx_result; sdo = tx_sr[127]; tx_active = 1;
            end
            // done is dropped again part-way through the read-back.
            if (done_hold > 0) begin
                done_hold--;
                if (done_hold == 0 && done_delay != -2) done = 1'b0;
            end
            sck_prev  = sck;
            load_prev = load;
            sdi_prev  = sdi;
        end
    end

    // Compare one value against its expectation and tally the result.
    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Run one full transaction for a vector and check frame, timing and result.
    task automatic applyStimulus(input vec_t v, input string tag);
        bit           seen;
        logic [127:0] ct_at_valid;
        logic         busy_at_valid;
        int           n_valid;
        int           start_cyc;
        seen = 0; n_valid = 0; busy_at_valid = 0; ct_at_valid = '0;
        tx_result  = v.ct;
        done_delay = v.delay;
        @(negedge clk);
        key = v.key; plaintext = v.pt; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (v.spam && load) begin
                start = ((i % 37) == 3); key = ~v.key; plaintext = ~v.pt;
            end else begin
                start = 1'b0; key = v.key; plaintext = v.pt;
            end
            if (valid) begin
                seen = 1; n_valid = 1; ct_at_valid = cyphertext; busy_at_valid = busy;
            end
        end
        start = 1'b0; key = v.key; plaintext = v.pt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) n_valid++;
        end
        checkOutput({tag, " completed"}, 256'(seen), 256'd1);
        checkOutput({tag, " cyphertext"}, 256'(ct_at_valid), 256'(v.ct));
        checkOutput({tag, " busy at valid"}, 256'(busy_at_valid), 256'd1);
        checkOutput({tag, " valid pulses"}, 256'(n_valid), 256'd1);
        checkOutput({tag, " busy after"}, 256'(busy), 256'd0);
        checkOutput({tag, " held cyphertext"}, 256'(cyphertext), 256'(v.ct));
        checkOutput({tag, " frame"}, rx_frame, {v.pt, v.key});
        checkOutput({tag, " frame bits"}, 256'(rx_cnt), 256'd256);
        checkOutput({tag, " sck rises"}, 256'(rise_cnt), 256'd384);
        checkOutput({tag, " sdi glitches"}, 256'(sdi_glitch), 256'd0);
        checkOutput({tag, " load rise delay"}, 256'(load_rise_cyc - start_cyc), 256'd1);
        checkOutput({tag, " load fall delay"}, 256'(load_fall_cyc - start_cyc),
                    256'(1 + 512 * CD));
        checkOutput({tag, " error"}, 256'(error), 256'd0);
        if (v.delay == -2) begin
            checkOutput({tag, " no stall"},
                        256'((first_in_rise_cyc - load_fall_cyc) >= 1 + 2 * CD &&
                             (first_in_rise_cyc - load_fall_cyc) <= 2 + 2 * CD), 256'd1);
        end
    endtask

    // Check every output against its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, " sck"},        256'(sck),        256'd0);
        checkOutput({tag, " sdi"},        256'(sdi),        256'd0);
        checkOutput({tag, " load"},       256'(load),       256'd0);
        checkOutput({tag, " busy"},       256'(busy),       256'd0);
        checkOutput({tag, " valid"},      256'(valid),      256'd0);
        checkOutput({tag, " error"},      256'(error),      256'd0);
        checkOutput({tag, " cyphertext"}, 256'(cyphertext), 256'd0);
    endtask

    // Main sequence: reset, table vectors, mid-frame reset, optional timeout.
    initial begin
        bit reached;
        reset = 1'b1; start = 1'b0; key = '0; plaintext = '0;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 50, 1'b0};
        vecs[1] = '{128'hffffffffffffffffffffffffffffffff,
                    128'h00000000000000000000000000000000,
                    128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5, 50, 1'b1};
        vecs[2] = '{128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                    128'h80000000000000000000000000000001,
                    128'h00000000000000000000000000000001, -2, 1'b0};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0};

        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle busy", 256'(busy), 256'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of the outbound frame, then a fresh transfer.
        tx_result = vecs[1].ct; done_delay = 50;
        @(negedge clk);
        key = vecs[1].key; plaintext = vecs[1].pt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            if (rx_cnt >= 100) reached = 1;
        end
        checkOutput("reach bit 100", 256'(reached), 256'd1);
        reset = 1'b1;
        @(negedge clk);
        checkResetState("mid reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(vecs[0], "after reset");

`ifdef AES_SPI_HOST_TIMEOUT_EN
        // done never arrives: error must rise after TO cycles of waiting.
        begin
            bit seen_err;
            bit any_valid;
            int err_cyc;
            logic busy_at_err;
            seen_err = 0; any_valid = 0; err_cyc = 0; busy_at_err = 1'b1;
            tx_result = vecs[0].ct; done_delay = -1;
            @(negedge clk);
            key = vecs[0].key; plaintext = vecs[0].pt; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 4000 && !seen_err; i++) begin
                @(negedge clk);
                if (valid) any_valid = 1;
                if (error) begin
                    seen_err = 1; err_cyc = cyc; busy_at_err = busy;
                end
            end
            checkOutput("timeout error", 256'(seen_err), 256'd1);
            checkOutput("timeout delay", 256'(err_cyc - load_fall_cyc), 256'(TO));
            checkOutput("timeout busy", 256'(busy_at_err), 256'd0);
            checkOutput("timeout valid", 256'(any_valid), 256'd0);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checkOutput("error cleared", 256'(error), 256'd0);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_spi_host.md
# aes_spi_host

Controller-side SPI master for the AES core's SPI port. On a single `start` pulse it captures a 128-bit key and plaintext and asserts `load`. It then shifts 256 bits out to the core's `sdi` in SPI mode 0 (CPOL=0, CPHA=0), deasserts `load`, and waits for the core's `done`. Finally it clocks 128 bits of cyphertext back in from `sdo` and presents them with a one-cycle `valid` strobe. It sits on the FPGA side as the counterpart of the AES SPI peripheral, for self-test and for on-chip use without an MCU.

## Interface
Parameters:
- `CLK_DIV`, 4: `sck` half-period in `clk` cycles; legal range ≥ 2.
- `TIMEOUT_CYCLES`, 1_000_000: limit on the done wait; used only with `AES_SPI_HOST_TIMEOUT_EN`.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request pulse; sampled only while `busy`=0.
- `key` input 128: captured on the accepted `start`.
- `plaintext` input 128: captured on the accepted `start`.
- `sck` output 1: SPI clock, idle low.
- `sdi` output 1: serial data to the peripheral `sdi`.
- `load` output 1: frame-load strobe to the peripheral.
- `done` input 1: peripheral completion flag; asynchronous; passes through a 2-flop synchronizer.
- `sdo` input 1: serial data from the peripheral `sdo`.
- `cyphertext` output 128: last received result; held until the next transfer completes.
- `busy` output 1: high from the cycle after accepted `start` until the cycle `valid` is high, inclusive.
- `valid` output 1: one-cycle pulse when `cyphertext` updates.
- `error` output 1: sticky done-timeout flag; cleared by the next accepted `start`.

## Operation
States, in the shared enum:
- IDLE → SHIFT_OUT: on `start`=1 while in IDLE.
  - Capture `{plaintext,key}` into a 256-bit shift register.
  - Set `load`=1 and `sdi`=plaintext[127].
  - Clear `error`.
- SHIFT_OUT → WAIT_DONE: after 256 `sck` pulses.
  - MSB first: plaintext[127] down to plaintext[0], then key[127] down to key[0].
  - `sdi` advances on every `sck` falling edge.
  - `load` drops in the same cycle as the 256th falling edge.
- WAIT_DONE → SETTLE: when synchronized `done`=1.
- SETTLE → SHIFT_IN: after `CLK_DIV` cycles with `sck`=0. The peripheral drives cyphertext[127] on `sdo` before the first edge.
- SHIFT_IN → IDLE: after 128 `sck` pulses.
  - `sdo` is sampled on each `sck` rising edge into the LSB of a 128-bit register, shifting left, so the first bit lands in [127].
  - After the 128th falling edge, `cyphertext` loads, `valid`=1 for one cycle, and `busy`=0 on the following cycle.
- A `start` while `busy`=1 is ignored; there is no queueing.
- `done` already high on entry to WAIT_DONE: proceed immediately.
- `done` deasserting during SHIFT_IN: ignored.
- Reset, including mid-transfer, gives next cycle:
  - `sck`=0, `sdi`=0, `load`=0, `busy`=0, `valid`=0.
  - `error`=0, `cyphertext`=0, state=IDLE.
  - Divider and bit counters = 0.

## Timing
- Bit period is 2·`CLK_DIV` cycles.
- In a shift state, `sck` rises `CLK_DIV` cycles after the state entry or the previous fall, and falls `CLK_DIV` cycles after the rise.
- Data setup and hold at the peripheral is `CLK_DIV` cycles either side of the rising edge.
- `start` to `load`=1: 1 cycle.
- `start` to `load`=0: 1 + 512·`CLK_DIV` cycles.
- Synchronized `done` to first `sck` rise: 2 (synchronizer) + 2·`CLK_DIV` cycles.
- Last `sck` fall to `valid`: same cycle, with `cyphertext` registered.
- `sck`, `sdi` and `load` are driven directly from flops, with no combinational path from inputs.
- Bit counter is 9 bits and is compared against 255 and 127. Wrap past 255 is impossible by construction, and is an assertion target.

## Configuration
- `AES_SPI_HOST_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE.
  - After `TIMEOUT_CYCLES` without `done`, the block sets `error`=1, returns to IDLE, drops `busy`, and asserts no `valid`.
- Not defined:
  - The counter is not built and `error` is tied 0.
  - WAIT_DONE waits indefinitely.

## Structure
- Package `aes_spi_pkg` holds:
  - the state enum `spi_host_state_t` (IDLE, SHIFT_OUT, WAIT_DONE, SETTLE, SHIFT_IN);
  - `BLOCK_W`=128 and `FRAME_W`=256.
- Sub-module `sck_gen`:
  - inputs: `clk`, `reset`, `run`;
  - outputs: `sck`, plus one-cycle `rise` and `fall` strobes;
  - parameter: `CLK_DIV`.
- The top-level FSM consumes `rise`/`fall` and owns the shift registers, the counters and the synchronizer.

## Test plan
- FIPS-197 vector:
  - key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff, behavioral peripheral asserting `done` 50 cycles after `load` falls.
  - Peripheral captures the exact 256 bits.
  - `cyphertext`=69c4e0d86a7b0430d8cdb78070b4c55a with a single `valid` pulse.
- `CLK_DIV`=2:
  - Count 256+128 `sck` rises.
  - `sdi` is stable across every rise.
  - `load`=0 exactly 1+1024 cycles after `start`.
- `start` pulsed repeatedly during SHIFT_OUT → ignored; frame unchanged; one `valid` only.
- Reset asserted at bit 100 of SHIFT_OUT:
  - All outputs are at reset values next cycle.
  - A fresh `start` completes correctly.
- `done` held high before `start` → no stall; SHIFT_IN starts 2+2·`CLK_DIV` cycles after WAIT_DONE entry.
- With `AES_SPI_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=1000, `done` never asserted:
  - `error`=1 and `busy`=0 at cycle 1000 of WAIT_DONE; no `valid`.
  - The next `start` clears `error`.
